// File: rtl/port_event_responder.sv
// KCPSM6 port-bus responder: synchronises four input channels, queues
// their changes in an event FIFO, raises interrupt and drives an output register.
module port_event_responder #(
  parameter int IN_WIDTH   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] input_a,
  input  logic [IN_WIDTH-1:0] input_b,
  input  logic [IN_WIDTH-1:0] input_c,
  input  logic [IN_WIDTH-1:0] input_d,
  input  logic [7:0]          port_id,
  input  logic [7:0]          out_port,
  input  logic                write_strobe,
  input  logic                k_write_strobe,
  input  logic                read_strobe,
  output logic [7:0]          in_port,
  output logic                interrupt,
  input  logic                interrupt_ack,
  output logic [7:0]          out
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0][IN_WIDTH-1:0] raw;
  logic [3:0][IN_WIDTH-1:0] sync1;
  logic [3:0][IN_WIDTH-1:0] sync2;
  logic [3:0][IN_WIDTH-1:0] prev;
  logic [1:0]               mask_cnt;
  logic                     mask;
  logic [3:0]               change;
  logic [3:0]               pending;
  logic [3:0]               clr_mask;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          overflow;
  logic          irq_en;
  logic          full;
  logic          empty;

  logic       push_req;
  logic [1:0] sel_ch;
  logic [7:0] push_data;
  logic       push_ok;
  logic       drop;
  logic       pop;
  logic       wr_out;
  logic       wr_ctl;
  logic       flush;
  logic       clr_ovf;
  logic [7:0] rd_data;

  assign raw = {input_d, input_c, input_b, input_a};

  // Synchroniser and previous-value flops track continuously, even in reset,
  // so a steady input never looks like a change after release.
  always_ff @(posedge clk) begin
    sync1 <= raw;
    sync2 <= sync1;
    prev  <= sync2;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      mask_cnt <= 2'd2;
    else if (mask_cnt != 2'd0)
      mask_cnt <= mask_cnt - 2'd1;
  end

  assign mask = (mask_cnt != 2'd0);

  always_comb begin
    change = '0;
    for (int i = 0; i < 4; i++)
      change[i] = !mask && (sync2[i] != prev[i]);
  end

  always_comb begin
    push_req = 1'b0;
    sel_ch   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        push_req = 1'b1;
        sel_ch   = 2'(i);
      end
    end
  end

  assign push_data = {sel_ch, {(6-IN_WIDTH){1'b0}}, sync2[sel_ch]};
  assign clr_mask  = push_req ? (4'b0001 << sel_ch) : 4'b0000;

  assign empty   = (count == 5'd0);
  assign full    = (count == 5'(FIFO_DEPTH));
  assign pop     = read_strobe && (port_id == 8'h07) && !empty;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  assign wr_out = (write_strobe && port_id == 8'h05)
               || (k_write_strobe && port_id[3:0] == 4'h5);
  assign wr_ctl = (write_strobe && port_id == 8'h08)
               || (k_write_strobe && port_id[3:0] == 4'h8);
  assign flush   = wr_ctl && out_port[2];
  assign clr_ovf = wr_ctl && out_port[1];

  always_ff @(posedge clk) begin
    if (!reset_n)
      pending <= '0;
    else if (flush)
      pending <= '0;
    else
      pending <= (pending & ~clr_mask) | change;
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // A dropped event outranks a same-cycle clear so it is never lost silently.
  always_ff @(posedge clk) begin
    if (!reset_n)
      overflow <= 1'b0;
    else if (drop && !flush)
      overflow <= 1'b1;
    else if (clr_ovf)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en    <= 1'b0;
      out       <= '0;
      interrupt <= 1'b0;
    end else begin
      if (wr_ctl)
        irq_en <= out_port[0];
      if (wr_out)
        out <= out_port;
      interrupt <= interrupt_ack ? 1'b0 : (irq_en && !empty);
    end
  end

  always_comb begin
    rd_data = 8'h00;
    unique case (port_id)
      8'h01:   rd_data = {{(8-IN_WIDTH){1'b0}}, sync2[0]};
      8'h02:   rd_data = {{(8-IN_WIDTH){1'b0}}, sync2[1]};
      8'h03:   rd_data = {{(8-IN_WIDTH){1'b0}}, sync2[2]};
      8'h04:   rd_data = {{(8-IN_WIDTH){1'b0}}, sync2[3]};
      8'h05:   rd_data = out;
      8'h06:   rd_data = {count, overflow, full, empty};
      8'h07:   rd_data = empty ? 8'h00 : mem[rd_ptr];
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      in_port <= '0;
    else
      in_port <= rd_data;
  end

endmodule

// File: tb/tb_port_event_responder.sv
// Scoreboard bench for port_event_responder: stimulus queues expected
// responses, a negedge monitor pops and compares them.
module tb_port_event_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] input_a, input_b, input_c, input_d;
  logic [7:0] port_id, out_port;
  logic       write_strobe, k_write_strobe, read_strobe;
  logic [7:0] in_port;
  logic       interrupt, interrupt_ack;
  logic [7:0] out;

  logic       probe;
  int         probe_kind;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  port_event_responder #(.IN_WIDTH(2), .FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .input_a        (input_a),
    .input_b        (input_b),
    .input_c        (input_c),
    .input_d        (input_d),
    .port_id        (port_id),
    .out_port       (out_port),
    .write_strobe   (write_strobe),
    .k_write_strobe (k_write_strobe),
    .read_strobe    (read_strobe),
    .in_port        (in_port),
    .interrupt      (interrupt),
    .interrupt_ack  (interrupt_ack),
    .out            (out)
  );

  always #5 clk = ~clk;

  // kind 0: in_port, 1: interrupt, 2: out
  always @(negedge clk) begin
    if (read_strobe || probe) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow t=%0t", $time);
      end else begin
        exp_t e;
        logic [7:0] act;
        e = sb.pop_front();
        case (e.kind)
          1:       act = {7'b0, interrupt};
          2:       act = out;
          default: act = in_port;
        endcase
        n_checks++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input int kind, input logic [7:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [7:0] id, input logic [7:0] v, input string name);
    port_id = id;
    tick(1);
    read_strobe = 1'b1;
    push_exp(name, 0, v);
    tick(1);
    read_strobe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    port_id      = id;
    out_port     = d;
    write_strobe = 1'b1;
    tick(1);
    write_strobe = 1'b0;
  endtask

  task automatic wrk(input logic [7:0] id, input logic [7:0] d);
    port_id        = id;
    out_port       = d;
    k_write_strobe = 1'b1;
    tick(1);
    k_write_strobe = 1'b0;
  endtask

  task automatic chk(input int kind, input logic [7:0] v, input string name);
    probe_kind = kind;
    probe      = 1'b1;
    push_exp(name, kind, v);
    tick(1);
    probe = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    input_a        = 2'b11;
    input_b        = 2'b11;
    input_c        = 2'b11;
    input_d        = 2'b11;
    port_id        = 8'h00;
    out_port       = 8'h00;
    write_strobe   = 1'b0;
    k_write_strobe = 1'b0;
    read_strobe    = 1'b0;
    interrupt_ack  = 1'b0;
    probe          = 1'b0;
    probe_kind     = 0;

    // steady inputs across reset release produce no events
    tick(3);
    chk(0, 8'h00, "reset_in_port");
    chk(1, 8'h00, "reset_interrupt");
    chk(2, 8'h00, "reset_out");
    reset_n = 1'b1;
    tick(6);
    rd(8'h06, 8'h01, "t1_status_empty");
    rd(8'h01, 8'h03, "t1_sync_ch0");
    chk(1, 8'h00, "t1_interrupt");

    // all channels drop together, popped in channel order
    input_a = 2'b00;
    input_b = 2'b00;
    input_c = 2'b00;
    input_d = 2'b00;
    tick(10);
    rd(8'h07, 8'h00, "t2_ev_ch0");
    rd(8'h07, 8'h40, "t2_ev_ch1");
    rd(8'h07, 8'h80, "t2_ev_ch2");
    rd(8'h07, 8'hC0, "t2_ev_ch3");
    input_b = 2'b10;
    tick(8);
    rd(8'h07, 8'h42, "t2_head_b");
    rd(8'h06, 8'h01, "t2_status_after_pop");
    chk(1, 8'h00, "t2_interrupt_disabled");

    // simultaneous changes on a and d
    input_a = 2'b01;
    input_d = 2'b01;
    tick(8);
    rd(8'h06, 8'h10, "t3_status_count2");
    rd(8'h07, 8'h01, "t3_first_ch0");
    rd(8'h07, 8'hC1, "t3_second_ch3");
    rd(8'h06, 8'h01, "t3_status_empty");

    // interrupt and acknowledge
    wr(8'h08, 8'h01);
    tick(1);
    chk(1, 8'h00, "t4_int_empty");
    input_c = 2'b11;
    tick(8);
    chk(1, 8'h01, "t4_int_pending");
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    chk(1, 8'h00, "t4_int_acked");
    chk(1, 8'h01, "t4_int_reassert");
    rd(8'h07, 8'h83, "t4_head_c");
    tick(2);
    chk(1, 8'h00, "t4_int_drained");
    wr(8'h08, 8'h00);

    // overflow: nine events into an eight-entry FIFO
    for (int k = 0; k < 9; k++) begin
      input_a = (k % 2 == 0) ? 2'b10 : 2'b01;
      tick(2);
    end
    tick(8);
    rd(8'h06, 8'h46, "t5_status_full_ovf");
    wr(8'h08, 8'h02);
    rd(8'h06, 8'h42, "t5_status_ovf_clr");
    rd(8'h07, 8'h02, "t5_oldest_event");
    rd(8'h06, 8'h38, "t5_status_count7");
    wr(8'h08, 8'h04);
    rd(8'h06, 8'h01, "t5_status_flushed");

    // output register, OUTPUTK and decode
    wr(8'h05, 8'h5A);
    chk(2, 8'h5A, "t6_out_write");
    rd(8'h05, 8'h5A, "t6_out_readback");
    wrk(8'hF5, 8'h3C);
    chk(2, 8'h3C, "t6_out_outputk");
    wr(8'h15, 8'h11);
    chk(2, 8'h3C, "t6_out_fullcmp");
    wr(8'h09, 8'h77);
    chk(2, 8'h3C, "t6_out_unmapped");
    rd(8'h20, 8'h00, "t6_rd_unmapped");
    rd(8'h07, 8'h00, "t6_rd_head_empty");
    rd(8'h01, 8'h02, "t6_sync_a");
    rd(8'h02, 8'h02, "t6_sync_b");
    rd(8'h03, 8'h03, "t6_sync_c");
    rd(8'h04, 8'h01, "t6_sync_d");

    // reset mid-operation discards queued events
    wr(8'h08, 8'h01);
    input_b = 2'b01;
    tick(8);
    chk(1, 8'h01, "t7_int_before_reset");
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    rd(8'h06, 8'h01, "t7_status_after_reset");
    chk(1, 8'h00, "t7_int_after_reset");
    chk(2, 8'h00, "t7_out_after_reset");

    tick(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
